// File: rtl/spi_xfer_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the SPI transfer arbiter.
// Shifter widths follow spi_defines.v; defaults apply when that file is absent.
`ifndef SPI_MAX_CHAR
`define SPI_MAX_CHAR 128
`endif
`ifndef SPI_CHAR_LEN_BITS
`define SPI_CHAR_LEN_BITS 7
`endif

package spi_xfer_arbiter_pkg;

    localparam int ID_W          = 3;
    localparam int LEN_W         = 5;
    localparam int DATA_W        = 32;
    localparam int MAX_CHAR      = `SPI_MAX_CHAR;
    localparam int CHAR_LEN_BITS = `SPI_CHAR_LEN_BITS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // A requester length of 0 encodes a full 32-bit character.
    function automatic logic [CHAR_LEN_BITS-1:0] char_len(input logic [LEN_W-1:0] len);
        logic [CHAR_LEN_BITS-1:0] r;
        if (len == '0) r = CHAR_LEN_BITS'(DATA_W);
        else           r = CHAR_LEN_BITS'(len);
        return r;
    endfunction

endpackage

// File: rtl/spi_xfer_arbiter_pick.sv
// Grant picker: first pending request found when scanning upward from ptr_i.
// Fixed priority is ptr_i tied to 0; round-robin (SPI_XARB_RR_EN) drives a pointer.
module spi_arb_pick
    import spi_xfer_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] slot;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        slot  = '0;
        for (int k = 0; k < NREQ; k++) begin
            slot = IDX_W'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[slot]) begin
                found       = 1'b1;
                gnt_o[slot] = 1'b1;
                idx_o       = ID_W'(slot);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI shift engine among NREQ requesters and returns tagged rx words.
// Define SPI_XARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request; grant strobe and capture of winner
// ST_LOAD  | one-cycle parallel load of tx word into the shifter
// ST_START | sh_go held until the shifter reports transfer in progress
// ST_BUSY  | shifting; on sh_tip low capture rx word
// ST_RESP  | rsp_valid held until the consumer accepts
module spi_xfer_arbiter
    import spi_xfer_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int SS_NB = 8
) (
    input  logic                     wb_clk,
    input  logic                     wb_reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    input  logic [NREQ*SS_NB-1:0]    req_ss,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [MAX_CHAR-1:0]      sh_p_in,
    output logic [3:0]               sh_latch,
    output logic [3:0]               sh_byte_sel,
    output logic [CHAR_LEN_BITS-1:0] sh_len,
    output logic                     sh_go,
    input  logic                     sh_tip,
    input  logic [MAX_CHAR-1:0]      sh_p_out,
    output logic [SS_NB-1:0]         ss_pad_o
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [SS_NB-1:0]    ss_q, ss_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]     pick_gnt;
    logic [ID_W-1:0]     pick_idx;
    logic [ID_W-1:0]     pick_ptr;
    logic                pick_any;
    logic                unused_p_out_hi;

    // Only the low word of the shifter is meaningful to requesters.
    assign unused_p_out_hi = ^sh_p_out[MAX_CHAR-1:DATA_W];

    spi_arb_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (pick_ptr),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

`ifdef SPI_XARB_RR_EN
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NREQ - 1);
    logic [ID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_IDLE && pick_any) begin
            ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = '0;
`endif

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        len_d       = len_q;
        ss_d        = ss_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        req_ready   = '0;
        rsp_valid   = 1'b0;
        sh_latch    = '0;
        sh_byte_sel = '0;
        sh_go       = 1'b0;
        sh_len      = '0;
        sh_p_in     = '0;
        ss_pad_o    = '1;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready = pick_gnt;
                    data_d    = req_data[DATA_W*pick_idx +: DATA_W];
                    len_d     = req_len[LEN_W*pick_idx +: LEN_W];
                    ss_d      = req_ss[SS_NB*pick_idx +: SS_NB];
                    id_d      = pick_idx;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sh_latch              = 4'b0001;
                sh_byte_sel           = 4'hF;
                sh_p_in[DATA_W-1:0]   = data_q;
                sh_len                = char_len(len_q);
                ss_pad_o              = ~ss_q;
                state_d               = ST_START;
            end
            ST_START: begin
                sh_go    = 1'b1;
                sh_len   = char_len(len_q);
                ss_pad_o = ~ss_q;
                if (sh_tip) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                sh_len   = char_len(len_q);
                ss_pad_o = ~ss_q;
                if (!sh_tip) begin
                    rsp_data_d = sh_p_out[DATA_W-1:0];
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            len_q      <= '0;
            ss_q       <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            len_q      <= len_d;
            ss_q       <= ss_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_id   = id_q;
    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Randomized bench for spi_xfer_arbiter with a behavioural shifter and arbitration model.
module tb_spi_xfer_arbiter;
    import spi_xfer_arbiter_pkg::*;

    localparam int NR = 4;

    logic                     wb_clk = 1'b0;
    logic                     wb_reset;
    logic [NR-1:0]            req_valid, req_ready;
    logic [NR*32-1:0]         req_data;
    logic [NR*5-1:0]          req_len;
    logic [NR*8-1:0]          req_ss;
    logic                     rsp_valid, rsp_ready;
    logic [2:0]               rsp_id;
    logic [31:0]              rsp_data;
    logic [MAX_CHAR-1:0]      sh_p_in, sh_p_out;
    logic [3:0]               sh_latch, sh_byte_sel;
    logic [CHAR_LEN_BITS-1:0] sh_len;
    logic                     sh_go, sh_tip;
    logic [7:0]               ss_pad_o;

    int errors = 0;
    int checks = 0;
    int mptr;
    logic [31:0] sh_mask;
    int sh_busy_min, sh_busy_max;

    spi_xfer_arbiter #(.NREQ(NR), .SS_NB(8)) dut (
        .wb_clk(wb_clk), .wb_reset(wb_reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_len(req_len), .req_ss(req_ss),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .sh_p_in(sh_p_in), .sh_latch(sh_latch), .sh_byte_sel(sh_byte_sel),
        .sh_len(sh_len), .sh_go(sh_go), .sh_tip(sh_tip),
        .sh_p_out(sh_p_out), .ss_pad_o(ss_pad_o)
    );

    always #5 wb_clk = ~wb_clk;

    // Behavioural shifter: latches p_in, answers go after 0..2 cycles, runs for a
    // random time, then returns latched word XOR sh_mask with junk in the upper bits.
    int ph, dly, bcnt;
    logic [31:0] lat;
    initial begin
        sh_tip = 1'b0; sh_p_out = '0; ph = 0; dly = 0; bcnt = 0; lat = '0;
        forever begin
            @(posedge wb_clk); #1;
            if (wb_reset) begin
                sh_tip = 1'b0; ph = 0;
            end else begin
                if (sh_latch[0]) lat = sh_p_in[31:0];
                case (ph)
                    0: if (sh_go) begin
                        dly  = $urandom_range(2, 0);
                        bcnt = $urandom_range(sh_busy_max, sh_busy_min);
                        if (dly == 0) begin sh_tip = 1'b1; ph = 2; end
                        else ph = 1;
                    end
                    1: begin
                        dly--;
                        if (dly == 0) begin sh_tip = 1'b1; ph = 2; end
                    end
                    default: begin
                        bcnt--;
                        if (bcnt <= 0) begin
                            sh_tip   = 1'b0;
                            sh_p_out = {$urandom, $urandom, $urandom, $urandom};
                            sh_p_out[31:0] = lat ^ sh_mask;
                            ph = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Arbitration rule: scan upward from the pointer (round-robin) or from 0.
    function automatic int model_winner(input logic [NR-1:0] v, input int ptr);
        int start;
        start = ptr;
`ifndef SPI_XARB_RR_EN
        start = 0;
`endif
        for (int k = 0; k < NR; k++) if (v[(start + k) % NR]) return (start + k) % NR;
        return -1;
    endfunction

    task automatic model_grant(input int w);
        mptr = (w + 1) % NR;
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] l, input logic [7:0] s);
        req_data[32*i +: 32] = d;
        req_len[5*i +: 5]    = l;
        req_ss[8*i +: 8]     = s;
    endtask

    task automatic do_reset();
        wb_reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge wb_clk);
        #1 wb_reset = 1'b0;
        mptr = 0;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(posedge wb_clk); #1;
        rsp_ready = 1'b0;
    endtask

    // Observation of one transfer, sampled on the falling edge.
    logic [3:0]               o_gnt, o_lat, o_bsel;
    int                       o_rdy, o_lcnt;
    logic [CHAR_LEN_BITS-1:0] o_len;
    logic [MAX_CHAR-1:0]      o_pin;
    logic [7:0]               o_ssl, o_ssb, o_ssr;
    logic [2:0]               o_id;
    logic [31:0]              o_dat;
    bit                       o_to;

    task automatic observe_xfer(input bit drop_after_grant);
        o_gnt = '0; o_lat = '0; o_bsel = '0; o_rdy = 0; o_lcnt = 0; o_len = '0;
        o_pin = '0; o_ssl = '0; o_ssb = '0; o_ssr = '0; o_id = '0; o_dat = '0; o_to = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge wb_clk);
            if (req_ready != '0) begin o_rdy++; if (o_gnt == '0) o_gnt = req_ready; end
            if (sh_latch != '0) begin
                o_lcnt++; o_lat = sh_latch; o_bsel = sh_byte_sel; o_len = sh_len;
                o_pin = sh_p_in; o_ssl = ss_pad_o;
            end
            if (sh_tip) o_ssb = ss_pad_o;
            if (rsp_valid) begin
                o_ssr = ss_pad_o; o_id = rsp_id; o_dat = rsp_data; o_to = 1'b0;
                break;
            end
            @(posedge wb_clk); #1;
            if (drop_after_grant && o_gnt != '0) req_valid = req_valid & ~o_gnt;
        end
    endtask

    task automatic test_reset();
        wb_reset = 1'b1;
        repeat (2) @(posedge wb_clk);
        @(negedge wb_clk);
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %0h want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0h want 0", rsp_valid); end
        checks++; if (rsp_id !== 3'd0) begin errors++; $display("FAIL reset_rsp_id: got %0h want 0", rsp_id); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %0h want 0", rsp_data); end
        checks++; if (sh_latch !== 4'h0) begin errors++; $display("FAIL reset_sh_latch: got %0h want 0", sh_latch); end
        checks++; if (sh_byte_sel !== 4'h0) begin errors++; $display("FAIL reset_sh_byte_sel: got %0h want 0", sh_byte_sel); end
        checks++; if (sh_go !== 1'b0) begin errors++; $display("FAIL reset_sh_go: got %0h want 0", sh_go); end
        checks++; if (sh_len !== '0) begin errors++; $display("FAIL reset_sh_len: got %0h want 0", sh_len); end
        checks++; if (sh_p_in !== '0) begin errors++; $display("FAIL reset_sh_p_in: got %0h want 0", sh_p_in); end
        checks++; if (ss_pad_o !== 8'hFF) begin errors++; $display("FAIL reset_ss_pad_o: got %0h want ff", ss_pad_o); end
        @(posedge wb_clk); #1 wb_reset = 1'b0;
        mptr = 0;
    endtask

    task automatic test_single();
        logic [MAX_CHAR-1:0] exp_pin;
        exp_pin = '0; exp_pin[31:0] = 32'hA5A5_0F0F;
        sh_mask = $urandom; sh_busy_min = 1; sh_busy_max = 4;
        set_req(0, 32'hA5A5_0F0F, 5'd8, 8'h01);
        req_valid = 4'b0001;
        observe_xfer(1'b1);
        checks++; if (o_to !== 1'b0) begin errors++; $display("FAIL single_timeout: got %0d want 0", o_to); end
        checks++; if (o_gnt !== 4'b0001) begin errors++; $display("FAIL single_grant: got %0h want 1", o_gnt); end
        checks++; if (o_rdy !== 1) begin errors++; $display("FAIL single_ready_cycles: got %0d want 1", o_rdy); end
        checks++; if (o_lcnt !== 1) begin errors++; $display("FAIL single_latch_cycles: got %0d want 1", o_lcnt); end
        checks++; if (o_lat !== 4'b0001) begin errors++; $display("FAIL single_latch: got %0h want 1", o_lat); end
        checks++; if (o_bsel !== 4'hF) begin errors++; $display("FAIL single_byte_sel: got %0h want f", o_bsel); end
        checks++; if (int'(o_len) !== 8) begin errors++; $display("FAIL single_len: got %0d want 8", o_len); end
        checks++; if (o_pin !== exp_pin) begin errors++; $display("FAIL single_p_in: got %0h want %0h", o_pin, exp_pin); end
        checks++; if (o_ssl !== 8'hFE) begin errors++; $display("FAIL single_ss_load: got %0h want fe", o_ssl); end
        checks++; if (o_ssb !== 8'hFE) begin errors++; $display("FAIL single_ss_busy: got %0h want fe", o_ssb); end
        checks++; if (o_ssr !== 8'hFF) begin errors++; $display("FAIL single_ss_resp: got %0h want ff", o_ssr); end
        checks++; if (o_id !== 3'd0) begin errors++; $display("FAIL single_rsp_id: got %0d want 0", o_id); end
        checks++; if (o_dat !== (32'hA5A5_0F0F ^ sh_mask)) begin errors++; $display("FAIL single_rsp_data: got %0h want %0h", o_dat, 32'hA5A5_0F0F ^ sh_mask); end
        model_grant(0);
        ack_rsp();
        @(negedge wb_clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %0h want 0", rsp_valid); end
    endtask

    task automatic test_loopback();
        int id; logic [31:0] d; logic [7:0] s;
        id = $urandom_range(NR - 1, 0); d = $urandom; s = 8'($urandom);
        sh_mask = '0;
        set_req(id, d, 5'd0, s);
        @(posedge wb_clk); #1 req_valid = 4'(1 << id);
        observe_xfer(1'b1);
        checks++; if (o_to !== 1'b0) begin errors++; $display("FAIL loop_timeout: got %0d want 0", o_to); end
        checks++; if (o_gnt !== 4'(1 << id)) begin errors++; $display("FAIL loop_grant: got %0h want %0h", o_gnt, 4'(1 << id)); end
        checks++; if (int'(o_len) !== 32) begin errors++; $display("FAIL loop_len: got %0d want 32", o_len); end
        checks++; if (o_dat !== d) begin errors++; $display("FAIL loop_rsp_data: got %0h want %0h", o_dat, d); end
        checks++; if (int'(o_id) !== id) begin errors++; $display("FAIL loop_rsp_id: got %0d want %0d", o_id, id); end
        model_grant(id);
        ack_rsp();
    endtask

    task automatic test_random();
        logic [31:0] td[NR]; logic [4:0] tl[NR]; logic [7:0] ts[NR];
        logic [NR-1:0] v; int w; int el;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < NR; i++) begin
                td[i] = $urandom; tl[i] = 5'($urandom_range(31, 0));
                ts[i] = (it == 3) ? 8'h00 : 8'($urandom);
                set_req(i, td[i], tl[i], ts[i]);
            end
            v = 4'($urandom_range(15, 1)); w = model_winner(v, mptr);
            sh_mask = $urandom; sh_busy_min = 1; sh_busy_max = 5;
            req_valid = v;
            observe_xfer(1'b0);
            req_valid = '0;
            el = (tl[w] == 5'd0) ? 32 : int'(tl[w]);
            checks++; if (o_to !== 1'b0) begin errors++; $display("FAIL rand_timeout it=%0d: got %0d want 0", it, o_to); end
            checks++; if (o_gnt !== 4'(1 << w)) begin errors++; $display("FAIL rand_grant it=%0d: got %0h want %0h", it, o_gnt, 4'(1 << w)); end
            checks++; if (int'(o_id) !== w) begin errors++; $display("FAIL rand_rsp_id it=%0d: got %0d want %0d", it, o_id, w); end
            checks++; if (o_dat !== (td[w] ^ sh_mask)) begin errors++; $display("FAIL rand_rsp_data it=%0d: got %0h want %0h", it, o_dat, td[w] ^ sh_mask); end
            checks++; if (int'(o_len) !== el) begin errors++; $display("FAIL rand_len it=%0d: got %0d want %0d", it, o_len, el); end
            checks++; if (o_ssl !== ~ts[w]) begin errors++; $display("FAIL rand_ss it=%0d: got %0h want %0h", it, o_ssl, ~ts[w]); end
            model_grant(w);
            ack_rsp();
        end
    endtask

    task automatic test_rr_order();
        logic [31:0] td[NR]; int w;
        do_reset();
        sh_mask = '0;
        for (int i = 0; i < NR; i++) begin td[i] = $urandom; set_req(i, td[i], 5'd16, 8'(1 << i)); end
        req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            w = model_winner(4'hF, mptr);
            observe_xfer(1'b0);
            checks++; if (o_gnt !== 4'(1 << w)) begin errors++; $display("FAIL rr_grant n=%0d: got %0h want %0h", n, o_gnt, 4'(1 << w)); end
            checks++; if (int'(o_id) !== w) begin errors++; $display("FAIL rr_rsp_id n=%0d: got %0d want %0d", n, o_id, w); end
            checks++; if (o_dat !== td[w]) begin errors++; $display("FAIL rr_rsp_data n=%0d: got %0h want %0h", n, o_dat, td[w]); end
            model_grant(w);
            ack_rsp();
        end
        req_valid = '0;
    endtask

    task automatic test_hold();
        logic [31:0] d0, d1; int bad_v, bad_d, bad_g;
        d0 = $urandom; d1 = $urandom; sh_mask = $urandom;
        set_req(0, d0, 5'd12, 8'h10); set_req(1, d1, 5'd0, 8'h20);
        req_valid = 4'b0001;
        observe_xfer(1'b1);
        checks++; if (o_to !== 1'b0) begin errors++; $display("FAIL hold_timeout: got %0d want 0", o_to); end
        model_grant(0);
        req_valid = 4'b0010;
        bad_v = 0; bad_d = 0; bad_g = 0;
        repeat (20) begin
            @(negedge wb_clk);
            if (rsp_valid !== 1'b1) bad_v++;
            if (rsp_data !== (d0 ^ sh_mask)) bad_d++;
            if (req_ready !== 4'h0 || sh_latch !== 4'h0) bad_g++;
        end
        checks++; if (bad_v !== 0) begin errors++; $display("FAIL hold_rsp_valid: got %0d bad cycles want 0", bad_v); end
        checks++; if (bad_d !== 0) begin errors++; $display("FAIL hold_rsp_data: got %0d bad cycles want 0", bad_d); end
        checks++; if (bad_g !== 0) begin errors++; $display("FAIL hold_no_grant: got %0d bad cycles want 0", bad_g); end
        ack_rsp();
        observe_xfer(1'b1);
        checks++; if (o_gnt !== 4'b0010) begin errors++; $display("FAIL hold_next_grant: got %0h want 2", o_gnt); end
        checks++; if (o_dat !== (d1 ^ sh_mask)) begin errors++; $display("FAIL hold_next_data: got %0h want %0h", o_dat, d1 ^ sh_mask); end
        model_grant(1);
        ack_rsp();
    endtask

    task automatic test_withdraw();
        logic [31:0] d0; bit tip_seen, rsp_seen; int g_busy, g_post;
        d0 = $urandom; sh_mask = $urandom; sh_busy_min = 8; sh_busy_max = 8;
        set_req(0, d0, 5'd4, 8'h04); set_req(1, $urandom, 5'd4, 8'h08);
        req_valid = 4'b0001;
        @(posedge wb_clk); #1 req_valid = '0;
        tip_seen = 1'b0; rsp_seen = 1'b0; g_busy = 0; g_post = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge wb_clk);
            if (sh_tip) begin tip_seen = 1'b1; break; end
        end
        req_valid = 4'b0010;
        for (int c = 0; c < 100; c++) begin
            @(negedge wb_clk);
            if (req_ready != '0) g_busy++;
            if (rsp_valid) begin rsp_seen = 1'b1; break; end
        end
        req_valid = '0;
        checks++; if (tip_seen !== 1'b1) begin errors++; $display("FAIL withdraw_tip_seen: got %0d want 1", tip_seen); end
        checks++; if (rsp_seen !== 1'b1) begin errors++; $display("FAIL withdraw_rsp_seen: got %0d want 1", rsp_seen); end
        checks++; if (g_busy !== 0) begin errors++; $display("FAIL withdraw_grant_busy: got %0d want 0", g_busy); end
        checks++; if (rsp_id !== 3'd0) begin errors++; $display("FAIL withdraw_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_data !== (d0 ^ sh_mask)) begin errors++; $display("FAIL withdraw_rsp_data: got %0h want %0h", rsp_data, d0 ^ sh_mask); end
        model_grant(0);
        ack_rsp();
        repeat (10) begin
            @(negedge wb_clk);
            if (req_ready != '0 || sh_latch != '0 || rsp_valid) g_post++;
        end
        checks++; if (g_post !== 0) begin errors++; $display("FAIL withdraw_never_granted: got %0d activity cycles want 0", g_post); end
        sh_busy_min = 1; sh_busy_max = 5;
    endtask

    task automatic test_reset_busy();
        logic [31:0] d2; bit tip_seen; int bad;
        d2 = $urandom; sh_mask = $urandom; sh_busy_min = 6; sh_busy_max = 6;
        set_req(2, d2, 5'd20, 8'h80);
        req_valid = 4'b0100;
        @(posedge wb_clk); #1 req_valid = '0;
        tip_seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge wb_clk);
            if (sh_tip) begin tip_seen = 1'b1; break; end
        end
        checks++; if (tip_seen !== 1'b1) begin errors++; $display("FAIL rstbusy_tip_seen: got %0d want 1", tip_seen); end
        #2 wb_reset = 1'b1;
        #1;
        checks++; if (ss_pad_o !== 8'hFF) begin errors++; $display("FAIL rstbusy_ss_pad_o: got %0h want ff", ss_pad_o); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstbusy_rsp_valid: got %0h want 0", rsp_valid); end
        checks++; if (sh_go !== 1'b0 || sh_len !== '0) begin errors++; $display("FAIL rstbusy_shifter_ctl: got go=%0h len=%0h want 0", sh_go, sh_len); end
        repeat (2) @(posedge wb_clk);
        #1 wb_reset = 1'b0;
        mptr = 0;
        bad = 0;
        repeat (10) begin @(negedge wb_clk); if (rsp_valid !== 1'b0) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rstbusy_no_partial_rsp: got %0d cycles want 0", bad); end
        sh_busy_min = 1; sh_busy_max = 5;
        @(posedge wb_clk); #1 req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rstbusy_idle_grant: got %0h want 4", req_ready); end
        observe_xfer(1'b1);
        checks++; if (o_dat !== (d2 ^ sh_mask)) begin errors++; $display("FAIL rstbusy_after_data: got %0h want %0h", o_dat, d2 ^ sh_mask); end
        model_grant(2);
        ack_rsp();
    endtask

    initial begin
        wb_reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        req_data = '0; req_len = '0; req_ss = '0;
        sh_mask = '0; sh_busy_min = 1; sh_busy_max = 4; mptr = 0;
        test_reset();
        test_single();
        test_loopback();
        test_random();
        test_rr_order();
        test_hold();
        test_withdraw();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
